m_mc_ctrl: RTL

- Multicycle sequencer for the RV32I datapath (adder, imem, gen_imm, RF, ALU, dmem, muxes), replacing the single-cycle "everything every clock" scheme.
- Steps each instruction through IF/ID/EX/MEM/WB and waits on a shared memory ready handshake.
- Drives all datapath enables and mux selects, detects the halt convention (write to x30), and keeps cycle and retired-instruction counters.

---
 rtl/m_mc_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/m_mc_ctrl.sv
// Multicycle IF/ID/EX/MEM/WB sequencer for the RV32I datapath: drives enables
// and mux selects, handles memory wait/timeout, halts on a write to HALT_REG.
module m_mc_ctrl #(
   parameter int CNT_W    = 32,
   parameter int MAX_WAIT = 255,
   parameter int HALT_REG = 30
) (
   input  logic             w_clk,
   input  logic             w_rst_n,
   input  logic [31:0]      w_ir,
   input  logic             w_tkn,
   input  logic             w_mem_rdy,
   output logic             w_imem_req,
   output logic             w_ir_we,
   output logic             w_dmem_req,
   output logic             w_dmem_we,
   output logic             w_rf_we,
   output logic [1:0]       w_wb_sel,
   output logic             w_pc_we,
   output logic [1:0]       w_pc_sel,
   output logic             w_src2_imm,
   output logic [2:0]       r_state,
   output logic             w_halted,
   output logic [1:0]       r_err,
   output logic [CNT_W-1:0] r_cyc,
   output logic [CNT_W-1:0] r_instret
);

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      C_R, C_I, C_U, C_LD, C_ST, C_BR, C_JAL, C_JALR, C_ILL
   } cls_t;

   localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

   state_t            st;
   cls_t              cls;
   logic [WAIT_W-1:0] wait_cnt;
   logic              timeout;
   logic              rd_nz;
   logic              rd_halt;
   logic              src2_cls;
   logic              unused_ir;

   assign unused_ir = ^w_ir[31:12];
   assign r_state   = st;
   assign rd_nz     = (w_ir[11:7] != 5'd0);
   assign rd_halt   = (w_ir[11:7] == 5'(HALT_REG));
   // The wait that would reach MAX_WAIT is the one that trips the timeout.
   assign timeout   = (MAX_WAIT != 0) && (wait_cnt == WAIT_LAST);

   always_comb begin
      cls = C_ILL;
      case (w_ir[6:0])
         7'b0110011: cls = C_R;
         7'b0010011: cls = C_I;
         7'b0110111,
         7'b0010111: cls = C_U;
         7'b0000011: cls = C_LD;
         7'b0100011: cls = C_ST;
         7'b1100011: cls = C_BR;
         7'b1101111: cls = C_JAL;
         7'b1100111: cls = C_JALR;
         default:    cls = C_ILL;
      endcase
   end

   assign src2_cls = (cls != C_R) && (cls != C_BR) && (cls != C_ILL);

   // NOTE: state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         st        <= S_IF;
         r_err     <= 2'b00;
         r_cyc     <= '0;
         r_instret <= '0;
         wait_cnt  <= '0;
      end else begin
         if (st != S_HALT) r_cyc <= r_cyc + CNT_W'(1);
         case (st)
            S_IF: begin
               if (w_mem_rdy) begin
                  st       <= S_ID;
                  wait_cnt <= '0;
               end else if (timeout) begin
                  st       <= S_HALT;
                  r_err    <= 2'b10;
                  wait_cnt <= '0;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            S_ID: begin
               if (cls == C_ILL) begin
                  st    <= S_HALT;
                  r_err <= 2'b01;
               end else begin
                  st <= S_EX;
               end
            end
            S_EX: begin
               if (cls == C_BR) begin
                  st        <= S_IF;
                  r_instret <= r_instret + CNT_W'(1);
               end else if (cls == C_LD || cls == C_ST) begin
                  st <= S_MEM;
               end else begin
                  st <= S_WB;
               end
            end
            S_MEM: begin
               if (w_mem_rdy) begin
                  wait_cnt <= '0;
                  if (cls == C_ST) begin
                     st        <= S_IF;
                     r_instret <= r_instret + CNT_W'(1);
                  end else begin
                     st <= S_WB;
                  end
               end else if (timeout) begin
                  st       <= S_HALT;
                  r_err    <= 2'b10;
                  wait_cnt <= '0;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            S_WB: begin
               r_instret <= r_instret + CNT_W'(1);
               st        <= rd_halt ? S_HALT : S_IF;
            end
            S_HALT:  st <= S_HALT;
            default: st <= S_HALT;
         endcase
      end
   end

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      w_imem_req = 1'b0;
      w_ir_we    = 1'b0;
      w_dmem_req = 1'b0;
      w_dmem_we  = 1'b0;
      w_rf_we    = 1'b0;
      w_wb_sel   = 2'b00;
      w_pc_we    = 1'b0;
      w_pc_sel   = 2'b00;
      w_src2_imm = 1'b0;
      w_halted   = 1'b0;
      // Gated by reset so nothing can write while reset is asserted.
      if (w_rst_n) begin
         case (st)
            S_IF: begin
               w_imem_req = 1'b1;
               w_ir_we    = w_mem_rdy;
            end
            S_EX: begin
               if (cls == C_BR) begin
                  w_pc_we  = 1'b1;
                  w_pc_sel = w_tkn ? 2'b01 : 2'b00;
               end
            end
            S_MEM: begin
               w_dmem_req = 1'b1;
               w_dmem_we  = (cls == C_ST);
               w_pc_we    = (cls == C_ST) && w_mem_rdy;
            end
            S_WB: begin
               w_rf_we  = rd_nz;
               w_pc_we  = 1'b1;
               w_wb_sel = (cls == C_LD) ? 2'b01 :
                          (cls == C_JAL || cls == C_JALR) ? 2'b10 : 2'b00;
               w_pc_sel = (cls == C_JAL) ? 2'b01 :
                          (cls == C_JALR) ? 2'b10 : 2'b00;
            end
            S_HALT:  w_halted = 1'b1;
            default: ;
         endcase
         w_src2_imm = src2_cls && (st inside {S_ID, S_EX, S_MEM, S_WB});
      end
   end

endmodule
